hero_write_mux: RTL



---
 rtl/hero_mux_pkg.sv | 22 ++
 rtl/hero_write_mux_if.sv | 34 +++
 rtl/hero_rr_arb.sv | 30 +++
 rtl/hero_write_mux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hero_mux_pkg.sv
// Shared types for the hero write merger: cycle-type encoding, FSM state codes and
// the round-robin pointer helper.
package hero_mux_pkg;

   localparam int unsigned HERO_WIDTH = 36;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      VALID = 2'd1,
      DONE  = 2'd2
   } CYCLE_TYPE_E;

   // State codes kept as plain constants so legacy code can compare against raw bits.
   typedef logic [0:0] MUX_STATE_E;
   localparam MUX_STATE_E MUX_ARB    = 1'b0;
   localparam MUX_STATE_E MUX_LOCKED = 1'b1;

   function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/hero_write_mux_if.sv
// Bus bundle between NUM_CH hero write masters, the merger and the single hero target.
// The merger takes the slave view; the surrounding environment takes the master view.
interface hero_write_mux_if #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DATA_W    = 36,
   parameter int unsigned MAX_BEATS = 16
);
   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [NUM_CH*2-1:0]      in_cycle_type;
   logic [NUM_CH*DATA_W-1:0] in_wdat;
   logic [NUM_CH-1:0]        in_clk_en;
   logic                     out_valid;
   logic                     out_ready;
   logic [1:0]               out_cycle_type;
   logic [DATA_W-1:0]        out_wdat;
   logic                     out_clk_en;
   logic [CH_W-1:0]          out_ch;
   logic [CNT_W-1:0]         out_beat_idx;

   modport slave (
      input  in_valid, in_cycle_type, in_wdat, in_clk_en, out_ready,
      output in_ready, out_valid, out_cycle_type, out_wdat, out_clk_en, out_ch, out_beat_idx
   );

   modport master (
      output in_valid, in_cycle_type, in_wdat, in_clk_en, out_ready,
      input  in_ready, out_valid, out_cycle_type, out_wdat, out_clk_en, out_ch, out_beat_idx
   );

endinterface

// File: rtl/hero_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at NUM_CH.
module hero_rr_arb #(
   parameter int unsigned NUM_CH = 4,
   localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [CH_W-1:0]   gnt_idx,
   output logic              any_gnt
);

   logic [CH_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = '0;
      for (int unsigned off = 0; off < NUM_CH; off++) begin
         idx = CH_W'((32'(ptr) + off) % NUM_CH);
         if (!any_gnt && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            any_gnt  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hero_write_mux.sv
// N-channel hero write merger: round-robin arbitration locked per transaction, one-entry
// registered output with backpressure, beat indexing and forced termination of long bursts.
module hero_write_mux
   import hero_mux_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DATA_W    = HERO_WIDTH,
   parameter int unsigned MAX_BEATS = 16,
   localparam int unsigned CH_W     = $clog2(NUM_CH),
   localparam int unsigned CNT_W    = $clog2(MAX_BEATS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   hero_write_mux_if.slave   bus,
   output logic              err_overlen,
   output logic              busy
);

   typedef struct packed {
      CYCLE_TYPE_E       cycle_type;
      logic [DATA_W-1:0] wdat;
      logic              clk_en;
   } hero_beat_t;

   hero_beat_t        in_beat [NUM_CH];
   logic [NUM_CH-1:0] is_idle;
   logic [NUM_CH-1:0] req;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign in_beat[i] = '{
         cycle_type: CYCLE_TYPE_E'(bus.in_cycle_type[2*i +: 2]),
         wdat:       bus.in_wdat[DATA_W*i +: DATA_W],
         clk_en:     bus.in_clk_en[i]
      };
      assign is_idle[i] = (in_beat[i].cycle_type == IDLE);
      assign req[i]     = bus.in_valid[i] & ~is_idle[i];
   end

   MUX_STATE_E       state_q, state_d;
   logic [CH_W-1:0]  ptr_q, ptr_d;
   logic [CH_W-1:0]  lock_q, lock_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             out_valid_q;
   hero_beat_t       out_beat_q;
   logic [CH_W-1:0]  out_ch_q;
   logic [CNT_W-1:0] out_idx_q;
   logic             err_q;

   logic [NUM_CH-1:0] arb_gnt;
   logic [CH_W-1:0]   arb_idx;
   logic              arb_any;

   hero_rr_arb #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any_gnt (arb_any)
   );

   logic            can_load;
   logic [CH_W-1:0] sel_ch;
   logic            sel_vld;
   hero_beat_t      sel_beat;
   logic            accept;
   logic [CH_W-1:0] next_ptr;

   assign can_load = ~out_valid_q | bus.out_ready;

   always_comb begin
      if (state_q == MUX_LOCKED) begin
         sel_ch  = lock_q;
         sel_vld = req[lock_q];
      end else begin
         sel_ch  = arb_idx;
         sel_vld = arb_any;
      end
   end

   assign sel_beat = in_beat[sel_ch];
   assign accept   = sel_vld & can_load;
   assign next_ptr = CH_W'(rr_next(32'(sel_ch), NUM_CH));

   // IDLE beats are always drained; only the granted/locked channel sees can_load.
   always_comb begin
      bus.in_ready = '0;
      if (rst_n) begin
         if (state_q == MUX_LOCKED) begin
            bus.in_ready         = is_idle;
            bus.in_ready[lock_q] = is_idle[lock_q] | can_load;
         end else begin
            bus.in_ready = is_idle | (arb_gnt & {NUM_CH{can_load}});
         end
      end
   end

   hero_beat_t       load_beat;
   logic [CNT_W-1:0] load_idx;
   logic             load_err;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      lock_d    = lock_q;
      cnt_d     = cnt_q;
      load_beat = sel_beat;
      load_idx  = '0;
      load_err  = 1'b0;
      if (accept) begin
         if (state_q == MUX_ARB) begin
            if (sel_beat.cycle_type == DONE) begin
               ptr_d = next_ptr;
            end else begin
               lock_d  = sel_ch;
               cnt_d   = CNT_W'(1);
               state_d = MUX_LOCKED;
            end
         end else begin
            load_idx = cnt_q;
            if (sel_beat.cycle_type == DONE) begin
               state_d = MUX_ARB;
               ptr_d   = next_ptr;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(MAX_BEATS - 1)) begin
               // Burst hit the length limit: close it downstream and flag the overrun.
               load_beat.cycle_type = DONE;
               load_err             = 1'b1;
               state_d              = MUX_ARB;
               ptr_d                = next_ptr;
               cnt_d                = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MUX_ARB;
         ptr_q       <= '0;
         lock_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_beat_q  <= '0;
         out_ch_q    <= '0;
         out_idx_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_beat_q  <= load_beat;
            out_ch_q    <= sel_ch;
            out_idx_q   <= load_idx;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         err_q <= accept & load_err;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.out_cycle_type = out_beat_q.cycle_type;
   assign bus.out_wdat       = out_beat_q.wdat;
   assign bus.out_clk_en     = out_beat_q.clk_en;
   assign bus.out_ch         = out_ch_q;
   assign bus.out_beat_idx   = out_idx_q;
   assign err_overlen        = err_q;
   assign busy               = (state_q == MUX_LOCKED);

endmodule
